// File: rtl/hdlc_tx_channel.sv
// ---------------------------------------------------------------------------
// hdlc_tx_channel
//   HDLC transmit bit engine. Serialises bytes from the Tx buffer onto Tx,
//   one bit per Clk, LSB first. It frames each message with 0x7E flags,
//   inserts a 0 after ONES_LIMIT consecutive data ones, and generates the
//   abort pattern. Between frames it drives an idle line of ones. FCS bytes
//   arrive from upstream as ordinary data bytes.
//
// Ports
//   Clk              clock, all logic on the rising edge
//   Rst              synchronous reset, active-high
//   Tx_Start         pulse: begin a frame (accepted only while Tx_Busy=0)
//   Tx_Data[7:0]     next byte to send
//   Tx_DataValid     Tx_Data / Tx_LastByte hold a byte
//   Tx_LastByte      Tx_Data is the final byte of the frame
//   Tx_AbortFrame    pulse: abort the frame in progress
//   Tx_RdBuff        pulse: the byte offered on Tx_Data has been taken
//   Tx               serial line, registered
//   Tx_Busy          frame, abort or minimum-idle gap in progress
//   Tx_Done          pulse: frame completed normally
//   Tx_AbortedTrans  level: last frame was aborted; cleared by next Tx_Start
//   DbgState         current FSM state, for observation only
//
// Buffer handshake: Tx_DataValid acts as the valid signal and Tx_RdBuff as
//   the registered consume strobe. A byte is taken at the rising edge that
//   ends the last bit cycle of the start flag or of the current byte, if
//   Tx_DataValid is high at that edge. Tx_RdBuff is then high for the one
//   cycle that follows. The buffer must keep Tx_Data, Tx_LastByte and
//   Tx_DataValid stable until it sees Tx_RdBuff, and only then advance.
//   If no byte is valid at a take point, the frame is aborted.
// ---------------------------------------------------------------------------
module hdlc_tx_channel #(
    parameter int ONES_LIMIT = 5,
    parameter int MIN_IDLE   = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_LastByte,
    input  logic       Tx_AbortFrame,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic [2:0] DbgState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SFLAG = 3'd1,
        DATA  = 3'd2,
        EFLAG = 3'd3,
        ABORT = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic [7:0] FLAG = 8'h7E;
    localparam int OW = $clog2(ONES_LIMIT + 1);
    localparam int GW = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;
    localparam logic [OW-1:0] ONES_LAST = OW'(ONES_LIMIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_IDLE - 1);

    state_t        state;
    logic [2:0]    bitCnt;
    logic [2:0]    nextBit;
    logic [OW-1:0] onesCnt;
    logic [GW-1:0] gapCnt;
    logic [7:0]    shReg;
    logic          lastLatched;
    logic          stuffNow;     // the bit currently on Tx is an inserted 0
    logic          curBit;
    logic          needStuff;
    logic          byteEnd;
    logic          fetchPoint;

    assign nextBit = bitCnt + 3'd1;
    assign curBit  = shReg[bitCnt];

    // The data 1 now on the line completes a run of ONES_LIMIT ones, so the
    // next cycle must carry an inserted 0.
    assign needStuff = (state == DATA) && !stuffNow && curBit && (onesCnt == ONES_LAST);

    // A stuff bit that follows bit 7 still belongs to the current byte. The
    // byte therefore ends on that stuff cycle, not on bit 7.
    assign byteEnd = (state == DATA) && (bitCnt == 3'd7) && !needStuff;

    assign fetchPoint = ((state == SFLAG) && (bitCnt == 3'd7)) || (byteEnd && !lastLatched);

    assign Tx_Busy  = (state != IDLE);
    assign DbgState = state;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            Tx              <= 1'b1;
            bitCnt          <= 3'd0;
            onesCnt         <= '0;
            gapCnt          <= '0;
            shReg           <= 8'h00;
            lastLatched     <= 1'b0;
            stuffNow        <= 1'b0;
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
        end else begin
            Tx_RdBuff <= 1'b0;
            Tx_Done   <= 1'b0;
            case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    // A simultaneous Tx_AbortFrame is meaningless here and is ignored.
                    if (Tx_Start) begin
                        state           <= SFLAG;
                        bitCnt          <= 3'd0;
                        onesCnt         <= '0;
                        stuffNow        <= 1'b0;
                        lastLatched     <= 1'b0;
                        Tx              <= FLAG[0];
                        Tx_AbortedTrans <= 1'b0;
                    end
                end

                SFLAG, DATA: begin
                    // Track the run of transmitted data ones. Flags never count.
                    if (state == DATA && !stuffNow && curBit)
                        onesCnt <= onesCnt + OW'(1);
                    else
                        onesCnt <= '0;

                    if (Tx_AbortFrame) begin
                        // Abort has priority over any byte fetch due this edge.
                        state           <= ABORT;
                        bitCnt          <= 3'd0;
                        stuffNow        <= 1'b0;
                        onesCnt         <= '0;
                        Tx              <= 1'b0;
                        Tx_AbortedTrans <= 1'b1;
                    end else if (fetchPoint) begin
                        if (Tx_DataValid) begin
                            state       <= DATA;
                            shReg       <= Tx_Data;
                            lastLatched <= Tx_LastByte;
                            Tx_RdBuff   <= 1'b1;
                            bitCnt      <= 3'd0;
                            stuffNow    <= 1'b0;
                            Tx          <= Tx_Data[0];
                        end else begin
                            // Underrun: the buffer has nothing to give mid-frame.
                            state           <= ABORT;
                            bitCnt          <= 3'd0;
                            stuffNow        <= 1'b0;
                            onesCnt         <= '0;
                            Tx              <= 1'b0;
                            Tx_AbortedTrans <= 1'b1;
                        end
                    end else if (state == SFLAG) begin
                        bitCnt <= nextBit;
                        Tx     <= FLAG[nextBit];
                    end else if (byteEnd) begin
                        // The last byte is done, so send the closing flag.
                        state    <= EFLAG;
                        bitCnt   <= 3'd0;
                        stuffNow <= 1'b0;
                        onesCnt  <= '0;
                        Tx       <= FLAG[0];
                    end else if (needStuff) begin
                        // bitCnt holds, so the stuff bit does not consume a data bit.
                        stuffNow <= 1'b1;
                        Tx       <= 1'b0;
                    end else begin
                        stuffNow <= 1'b0;
                        bitCnt   <= nextBit;
                        Tx       <= shReg[nextBit];
                    end
                end

                EFLAG: begin
                    onesCnt <= '0;
                    if (Tx_AbortFrame) begin
                        state           <= ABORT;
                        bitCnt          <= 3'd0;
                        Tx              <= 1'b0;
                        Tx_AbortedTrans <= 1'b1;
                    end else if (bitCnt == 3'd7) begin
                        state   <= GAP;
                        gapCnt  <= '0;
                        Tx      <= 1'b1;
                        Tx_Done <= 1'b1;
                    end else begin
                        bitCnt <= nextBit;
                        Tx     <= FLAG[nextBit];
                    end
                end

                ABORT: begin
                    // The pattern is one 0 followed by seven 1s, then the idle gap.
                    Tx <= 1'b1;
                    if (bitCnt == 3'd7) begin
                        state  <= GAP;
                        gapCnt <= '0;
                    end else begin
                        bitCnt <= nextBit;
                    end
                end

                GAP: begin
                    Tx <= 1'b1;
                    if (gapCnt == GAP_LAST)
                        state <= IDLE;
                    else
                        gapCnt <= gapCnt + GW'(1);
                end

                default: begin
                    state <= IDLE;
                    Tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// ---------------------------------------------------------------------------
// tb_hdlc_tx_channel
//   Directed and randomised frames for hdlc_tx_channel. For each frame a
//   bit-list model derives the expected line stream: flags, stuffed data,
//   abort pattern and idle gap. The model also gives the expected
//   Tx_RdBuff cycles and the Tx_Done cycle. Cycle n is the n-th cycle after
//   the edge that samples Tx_Start. Outputs are sampled 1 ns after each
//   rising edge, and inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_hdlc_tx_channel;

    localparam int ONES_LIMIT = 5;
    localparam int MIN_IDLE   = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tx_Start;
    logic [7:0] Tx_Data;
    logic       Tx_DataValid;
    logic       Tx_LastByte;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_Busy;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic [2:0] DbgState;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] frameBytes [0:7];
    logic [0:0] expQ [$];
    int         rdExpQ [$];
    logic [7:0] flagByte = 8'h7E;

    int doneCyc;
    int rdCnt;

    hdlc_tx_channel #(
        .ONES_LIMIT(ONES_LIMIT),
        .MIN_IDLE  (MIN_IDLE)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_Start       (Tx_Start),
        .Tx_Data        (Tx_Data),
        .Tx_DataValid   (Tx_DataValid),
        .Tx_LastByte    (Tx_LastByte),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx_RdBuff      (Tx_RdBuff),
        .Tx             (Tx),
        .Tx_Busy        (Tx_Busy),
        .Tx_Done        (Tx_Done),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .DbgState       (DbgState)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testsRun++;
        assert (obs === expv) else begin
            testsFailed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- frame driver + model ----------------
    // n bytes from frameBytes. abortCyc>0 pulses Tx_AbortFrame in that cycle.
    // underrunIdx>=0 withholds that byte. startAbort raises Tx_AbortFrame
    // together with Tx_Start.
    task automatic runFrame(input int n, input int abortCyc, input int underrunIdx,
                            input bit startAbort, input string name,
                            output int doneOut, output int rdOut);
        logic [0:0] normQ [$];
        int  fetchCyc [0:7];
        int  ones, total, cutCyc, expE, expDone, idx, nRd, expBit;
        bit  aborted, v;

        // Expected stream for an uninterrupted frame.
        normQ = {};
        for (int b = 0; b < 8; b++) normQ.push_back(flagByte[b]);
        ones = 0;
        fetchCyc[0] = 8;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                v = frameBytes[i][b];
                normQ.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == ONES_LIMIT) begin
                    normQ.push_back(1'b0);
                    ones = 0;
                end
            end
            if (i < 7) fetchCyc[i+1] = normQ.size();
        end
        for (int b = 0; b < 8; b++) normQ.push_back(flagByte[b]);
        total = normQ.size();

        // Last cycle sent normally before an abort takes over.
        cutCyc = total + 1;
        if (underrunIdx >= 0 && underrunIdx < n) cutCyc = fetchCyc[underrunIdx];
        if (abortCyc > 0 && abortCyc < cutCyc) cutCyc = abortCyc;
        aborted = (cutCyc <= total);

        expQ = {};
        for (int k = 0; k < total && k < cutCyc; k++) expQ.push_back(normQ[k]);
        if (aborted) begin
            expQ.push_back(1'b0);
            repeat (7) expQ.push_back(1'b1);
        end
        repeat (MIN_IDLE) expQ.push_back(1'b1);
        expE    = expQ.size();
        expDone = aborted ? -1 : total + 1;

        rdExpQ = {};
        for (int i = 0; i < n; i++)
            if (fetchCyc[i] < cutCyc) rdExpQ.push_back(fetchCyc[i] + 1);
        nRd = rdExpQ.size();

        // Drive the frame.
        idx           = 0;
        Tx_Data       = frameBytes[0];
        Tx_LastByte   = (n == 1);
        Tx_DataValid  = (underrunIdx != 0);
        Tx_Start      = 1'b1;
        Tx_AbortFrame = startAbort;
        @(posedge Clk); #1;
        Tx_Start      = 1'b0;
        Tx_AbortFrame = 1'b0;
        doneOut = -1;
        rdOut   = 0;

        for (int cyc = 1; cyc <= expE + 2; cyc++) begin
            expBit = (cyc <= expE) ? int'(expQ[cyc-1]) : 1;
            check($sformatf("%s tx c%0d", name, cyc), Tx, expBit);
            check($sformatf("%s busy c%0d", name, cyc), Tx_Busy, (cyc <= expE) ? 1 : 0);
            if (cyc == 1) check($sformatf("%s aborted cleared", name), Tx_AbortedTrans, 0);
            if (Tx_Done) doneOut = (doneOut == -1) ? cyc : -2;
            if (Tx_RdBuff) begin
                rdOut++;
                if (rdExpQ.size() > 0)
                    check($sformatf("%s rdbuff cycle", name), cyc, rdExpQ.pop_front());
                else
                    check($sformatf("%s rdbuff extra", name), cyc, 0);
                idx++;
                if (idx < n) begin
                    Tx_Data     = frameBytes[idx];
                    Tx_LastByte = (idx == n - 1);
                end
            end
            Tx_DataValid  = (idx < n) && (idx != underrunIdx);
            // Start and abort pokes during the gap must be ignored.
            Tx_Start      = (cyc == expE - 3);
            Tx_AbortFrame = (cyc == abortCyc) || (cyc == expE - 1);
            @(posedge Clk); #1;
        end
        Tx_Start      = 1'b0;
        Tx_AbortFrame = 1'b0;
        Tx_DataValid  = 1'b0;

        check($sformatf("%s done cycle", name), doneOut, expDone);
        check($sformatf("%s rdbuff count", name), rdOut, nRd);
        check($sformatf("%s aborted flag", name), Tx_AbortedTrans, aborted);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int n, mode, abortCyc, underrunIdx;
        bit sa;

        Rst = 1'b1; Tx_Start = 1'b0; Tx_Data = 8'h00; Tx_DataValid = 1'b0;
        Tx_LastByte = 1'b0; Tx_AbortFrame = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset tx", Tx, 1);
        check("reset busy", Tx_Busy, 0);
        check("reset rdbuff", Tx_RdBuff, 0);
        check("reset done", Tx_Done, 0);
        check("reset aborted", Tx_AbortedTrans, 0);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // T1: single byte 0x00
        frameBytes[0] = 8'h00;
        runFrame(1, 0, -1, 1'b0, "t1", doneCyc, rdCnt);
        check("t1 done at 25", doneCyc, 25);
        check("t1 one rdbuff", rdCnt, 1);

        // T2: single byte 0xFF, one stuffed zero
        frameBytes[0] = 8'hFF;
        runFrame(1, 0, -1, 1'b0, "t2", doneCyc, rdCnt);
        check("t2 done at 26", doneCyc, 26);

        // T3: cross-byte stuffing
        frameBytes[0] = 8'hF0; frameBytes[1] = 8'h0F;
        runFrame(2, 0, -1, 1'b0, "t3", doneCyc, rdCnt);
        check("t3 two rdbuff", rdCnt, 2);
        check("t3 done at 34", doneCyc, 34);

        // T4: abort during bit 3 of byte 2 (byte 2 starts in cycle 17)
        frameBytes[0] = 8'h55; frameBytes[1] = 8'hA3; frameBytes[2] = 8'h3C;
        runFrame(3, 20, -1, 1'b0, "t4", doneCyc, rdCnt);
        check("t4 no done", doneCyc, -1);
        check("t4 aborted", Tx_AbortedTrans, 1);

        // T5: underrun before byte 2
        frameBytes[0] = 8'h12; frameBytes[1] = 8'h34; frameBytes[2] = 8'h56;
        runFrame(3, 0, 1, 1'b0, "t5", doneCyc, rdCnt);
        check("t5 one rdbuff", rdCnt, 1);
        check("t5 aborted", Tx_AbortedTrans, 1);

        // Start together with abort in IDLE still starts a frame.
        frameBytes[0] = 8'h81;
        runFrame(1, 0, -1, 1'b1, "startabort", doneCyc, rdCnt);

        // Abort on the final closing-flag bit wins over completion.
        frameBytes[0] = 8'h00;
        runFrame(1, 24, -1, 1'b0, "abortlast", doneCyc, rdCnt);

        // Abort on the same edge as the first fetch: no byte taken.
        frameBytes[0] = 8'h77; frameBytes[1] = 8'h88;
        runFrame(2, 8, -1, 1'b0, "abortfetch", doneCyc, rdCnt);
        check("abortfetch no rdbuff", rdCnt, 0);

        // T6: reset mid-DATA, then a clean T1 frame.
        Tx_Data = 8'hA5; Tx_DataValid = 1'b1; Tx_LastByte = 1'b0; Tx_Start = 1'b1;
        @(posedge Clk); #1;
        Tx_Start = 1'b0;
        repeat (12) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        Tx_DataValid = 1'b0;
        check("t6 tx after reset", Tx, 1);
        check("t6 busy after reset", Tx_Busy, 0);
        check("t6 done after reset", Tx_Done, 0);
        check("t6 aborted after reset", Tx_AbortedTrans, 0);
        repeat (3) begin
            @(posedge Clk); #1;
            check("t6 idle tx", Tx, 1);
            check("t6 idle busy", Tx_Busy, 0);
        end
        frameBytes[0] = 8'h00;
        runFrame(1, 0, -1, 1'b0, "t6", doneCyc, rdCnt);
        check("t6 done at 25", doneCyc, 25);

        // Randomised frames biased towards long runs of ones.
        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                frameBytes[i] = ($urandom_range(0, 3) == 0) ? 8'hFF :
                                (8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255)));
            mode        = $urandom_range(0, 3);
            abortCyc    = (mode == 0) ? $urandom_range(1, 16 + 8 * n) : 0;
            underrunIdx = (mode == 1) ? $urandom_range(0, n - 1) : -1;
            sa          = 1'($urandom_range(0, 1));
            runFrame(n, abortCyc, underrunIdx, sa, $sformatf("rnd%0d", f), doneCyc, rdCnt);
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
